rcv_buffer_ctrl: RTL and testbench
==================================

# rcv_buffer_ctrl

Receive-side controller between the UART `Receiver` and the byte consumer. It completes the receiver's four-phase RCV_REQ/RCV_ACK handshake and stores each byte in a DEPTH-entry FIFO. Bytes are presented downstream on a valid/ready interface. It also flags FIFO overflow and stuck handshakes, so the receiver never blocks on a slow consumer without visibility.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- TIMEOUT, 255: max cycles ACK stays high waiting for RCV_REQ to fall; 1..255.
- clk  input  1  system clock; all logic on rising edge.
- clr  input  1  reset, synchronous, active-high.
- RCV_REQ  input  1  byte-ready request from receiver.
- RCV_DATA  input  8  received byte; stable while RCV_REQ high.
- RCV_ACK  output  1  acknowledge to receiver; registered.
- OUT_DATA  output  8  head-of-FIFO byte; valid when OUT_VALID=1.
- OUT_VALID  output  1  FIFO not empty.
- OUT_READY  input  1  consumer takes byte when OUT_VALID&&OUT_READY at clock edge.
- COUNT  output  $clog2(DEPTH)+1  current occupancy.
- OVF_CNT  output  8  dropped-byte count; saturates at 255.
- HS_ERR  output  1  sticky handshake-timeout flag; cleared only by clr.

## Operation
- States:
  - SYNC: reset state. ACK=0. Stay while RCV_REQ=1. Go to IDLE when RCV_REQ=0. This prevents a REQ left high across clr from being captured twice.
  - IDLE: ACK=0.
    - RCV_REQ=1 and FIFO not full: write RCV_DATA, go ACK.
    - RCV_REQ=1 and full: go WAIT_SPACE (stall mode; see Configuration).
  - WAIT_SPACE: ACK=0. On first cycle with FIFO not full: write RCV_DATA, go ACK.
  - ACK: RCV_ACK=1; timeout counter increments each cycle.
    - RCV_REQ=0: go IDLE; ACK low the next cycle.
    - Counter reaches TIMEOUT with REQ still high: set HS_ERR, go SYNC (ACK drops).
- FIFO:
  - Circular buffer with rd/wr pointers of $clog2(DEPTH) bits; wrap at DEPTH.
  - COUNT tracks occupancy 0..DEPTH.
  - OUT_DATA = mem[rd_ptr], read combinationally.
  - OUT_VALID = (COUNT != 0).
- Write and read in the same cycle: both pointers advance, COUNT unchanged.
- Write eligibility uses COUNT at the start of the cycle. When full, a same-cycle read does not make room; the write is deferred one cycle.
- OUT_READY while empty: ignored; no pointer change.
- OVF_CNT increments only in drop mode and holds at 255.

## Timing
- Reset (clr=1 at edge) gives:
  - state=SYNC
  - RCV_ACK=0
  - pointers=0, COUNT=0
  - OUT_VALID=0, OUT_DATA=mem[0] (don't-care)
  - OVF_CNT=0, HS_ERR=0
- clr mid-handshake: ACK falls the next cycle and the FIFO contents are discarded. The block re-syncs via SYNC.
- Capture latency: RCV_REQ seen high in IDLE at edge N:
  - byte written at edge N
  - RCV_ACK=1 and OUT_VALID=1 (if previously empty) after edge N
- Release: RCV_REQ seen low in ACK at edge M; RCV_ACK=0 after edge M.
- Minimum handshake: 2 cycles per byte. Back-to-back throughput is 1 byte per 2 cycles.
- Timeout: ACK high for exactly TIMEOUT cycles before HS_ERR=1 and ACK=0 on the same edge.
- Pop: OUT_VALID&&OUT_READY at edge K; the next byte appears on OUT_DATA after edge K.

## Configuration
- RCV_DROP_ON_FULL_EN:
  - Defined: WAIT_SPACE is unused. REQ in IDLE with a full FIFO is acknowledged normally (go ACK) and the byte is discarded; OVF_CNT increments (saturating). The receiver is never stalled.
  - Undefined (default): stall mode. A full FIFO holds the receiver in WAIT_SPACE with ACK=0 and no data is lost. OVF_CNT stays 0.

## Test plan
- Single byte: after clr, REQ=1 with DATA=0xA5, drop REQ once ACK=1 -> ACK high 1 cycle after REQ; OUT_VALID=1, OUT_DATA=0xA5, COUNT=1. OUT_READY=1 for one edge -> COUNT=0.
- Fill and wrap (DEPTH=4, stall): push 0x01..0x04 with OUT_READY=0 -> COUNT=4. Fifth REQ (0x05) holds ACK=0. Pop one -> 0x05 written on the following edge. Drain order is 0x01..0x05.
- Drop mode (macro defined): fill 4 bytes, send 3 more -> each acknowledged, OVF_CNT=3, FIFO still holds 0x01..0x04. Forcing 300 extra bytes -> OVF_CNT=255.
- Simultaneous push/pop: COUNT=2, REQ captured on the same edge as a pop -> COUNT stays 2 and ordering is preserved.
- Timeout: hold REQ high 300 cycles -> ACK high exactly 255 cycles, then HS_ERR=1 and ACK=0. No second capture until REQ falls.
- Reset mid-handshake: clr asserted while ACK=1 and REQ=1 -> ACK=0, COUNT=0 next cycle. The same REQ is not re-captured; the next REQ after a low is captured normally.

Source files
------------

// File: rtl/rcv_buffer_ctrl.sv
// Receive buffer controller: completes the UART receiver's four-phase REQ/ACK handshake and queues bytes in a FIFO.
// Define RCV_DROP_ON_FULL_EN to acknowledge and discard bytes on a full FIFO; the default stalls the receiver.
module rcv_buffer_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     RCV_REQ,
    input  logic [7:0]               RCV_DATA,
    output logic                     RCV_ACK,
    output logic [7:0]               OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [7:0]               OVF_CNT,
    output logic                     HS_ERR
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_ACK
    } state_e;

    state_e          state_q, state_d;
    logic            ack_q, ack_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            hs_err_q, hs_err_d;
    logic [7:0]      ovf_q, ovf_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem [DEPTH];

    logic full;
    logic wr_en;
    logic rd_en;

    // Fullness is judged on the occupancy at the start of the cycle, so a same-cycle pop never frees a slot for the write.
    assign full  = (count_q == FULL_CNT);
    assign rd_en = OUT_READY && (count_q != '0);

    // NOTE: every always_comb output gets a default before the case; any path that skipped one would infer a latch.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        hs_err_d = hs_err_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (!RCV_REQ) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (RCV_REQ) begin
                    tmo_d = '0;
                    if (!full) begin
                        wr_en   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
`ifdef RCV_DROP_ON_FULL_EN
                        state_d = ST_ACK;
                        if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
`else
                        state_d = ST_WAIT_SPACE;
`endif
                    end
                end
            end
            ST_WAIT_SPACE: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!RCV_REQ) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    hs_err_d = 1'b1;
                    state_d  = ST_SYNC;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
        ack_d    = (state_d == ST_ACK);
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_SYNC;
            ack_q    <= 1'b0;
            tmo_q    <= '0;
            hs_err_q <= 1'b0;
            ovf_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            tmo_q    <= tmo_d;
            hs_err_q <= hs_err_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and COUNT define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= RCV_DATA;
    end

    assign RCV_ACK   = ack_q;
    assign OUT_DATA  = mem[rd_ptr_q];
    assign OUT_VALID = (count_q != '0);
    assign COUNT     = count_q;
    assign OVF_CNT   = ovf_q;
    assign HS_ERR    = hs_err_q;

endmodule

// File: tb/tb_rcv_buffer_ctrl.sv
// Self-checking bench for rcv_buffer_ctrl: a queue-based reference model is compared every cycle, plus directed literal checks.
// Covers the drop-on-full scenario when RCV_DROP_ON_FULL_EN is defined, the stall scenario otherwise.
module tb_rcv_buffer_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          RCV_REQ = 1'b0;
    logic [7:0]    RCV_DATA = 8'h00;
    logic          RCV_ACK;
    logic [7:0]    OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [CW-1:0] COUNT;
    logic [7:0]    OVF_CNT;
    logic          HS_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    rcv_buffer_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .clr       (clr),
        .RCV_REQ   (RCV_REQ),
        .RCV_DATA  (RCV_DATA),
        .RCV_ACK   (RCV_ACK),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .COUNT     (COUNT),
        .OVF_CNT   (OVF_CNT),
        .HS_ERR    (HS_ERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, the handshake is a few flags and a cycle count of ACK-high time.
    logic [7:0] m_q[$];
    bit         m_ready    = 1'b0;
    bit         m_ack      = 1'b0;
    bit         m_need_low = 1'b0;
    bit         m_stalled  = 1'b0;
    bit         m_hs_err   = 1'b0;
    int         m_ack_len  = 0;
    int         m_ovf      = 0;

    always @(posedge clk) begin
        if (clr) begin
            m_q.delete();
            m_ready    = 1'b1;
            m_ack      = 1'b0;
            m_need_low = 1'b1;
            m_stalled  = 1'b0;
            m_hs_err   = 1'b0;
            m_ack_len  = 0;
            m_ovf      = 0;
        end else if (m_ready) begin
            automatic bit was_full = (m_q.size() == DEPTH);
            automatic bit pop      = OUT_READY && (m_q.size() > 0);
            automatic bit push     = 1'b0;
            if (m_ack) begin
                if (!RCV_REQ) begin
                    m_ack = 1'b0;
                end else if (m_ack_len == TIMEOUT) begin
                    m_ack      = 1'b0;
                    m_hs_err   = 1'b1;
                    m_need_low = 1'b1;
                end else begin
                    m_ack_len++;
                end
            end else if (m_need_low) begin
                if (!RCV_REQ) m_need_low = 1'b0;
            end else if (m_stalled || RCV_REQ) begin
                if (!was_full) begin
                    push      = 1'b1;
                    m_ack     = 1'b1;
                    m_ack_len = 1;
                    m_stalled = 1'b0;
                end else begin
`ifdef RCV_DROP_ON_FULL_EN
                    m_ack     = 1'b1;
                    m_ack_len = 1;
                    if (m_ovf < 255) m_ovf++;
`else
                    m_stalled = 1'b1;
`endif
                end
            end
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(RCV_DATA);
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("m_ack",    RCV_ACK,   m_ack);
            check("m_count",  COUNT,     m_q.size());
            check("m_valid",  OUT_VALID, m_q.size() != 0);
            if (m_q.size() != 0) check("m_data", OUT_DATA, m_q[0]);
            check("m_ovf",    OVF_CNT,   m_ovf);
            check("m_hs_err", HS_ERR,    m_hs_err);
        end
    end

    // Inputs change 2 time units after the rising edge; literal checks are also taken there.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(input logic lvl, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (RCV_ACK === lvl) break;
            tick();
        end
        check("wait_ack", RCV_ACK, lvl);
    endtask

    task automatic send_byte(input logic [7:0] d);
        RCV_DATA = d;
        RCV_REQ  = 1'b1;
        wait_ack(1'b1, 20);
        RCV_REQ  = 1'b0;
        wait_ack(1'b0, 20);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic drain_expect(input logic [7:0] first, input int n);
        OUT_READY = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain_data", OUT_DATA, first + 8'(i));
            tick();
        end
        tick();
        OUT_READY = 1'b0;
        check("drain_empty", COUNT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        clr = 1'b1;
        tick();
        tick();
        check("rst_ack",   RCV_ACK,   1'b0);
        check("rst_count", COUNT,     0);
        check("rst_valid", OUT_VALID, 1'b0);
        check("rst_ovf",   OVF_CNT,   0);
        check("rst_hserr", HS_ERR,    1'b0);
        clr = 1'b0;
        tick();

        // Single byte: ACK one cycle after REQ, then pop.
        RCV_DATA = 8'hA5;
        RCV_REQ  = 1'b1;
        tick();
        check("single_ack",   RCV_ACK,   1'b1);
        check("single_valid", OUT_VALID, 1'b1);
        check("single_data",  OUT_DATA,  8'hA5);
        check("single_count", COUNT,     1);
        RCV_REQ = 1'b0;
        tick();
        check("single_release", RCV_ACK, 1'b0);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("single_pop", COUNT, 0);

`ifdef RCV_DROP_ON_FULL_EN
        do_reset();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        for (int i = 5; i <= 7; i++) send_byte(8'(i));
        check("drop_ovf3",  OVF_CNT, 3);
        check("drop_count", COUNT,   4);
        for (int i = 0; i < 300; i++) send_byte(8'hEE);
        check("drop_ovf_sat", OVF_CNT, 255);
        drain_expect(8'h01, 4);
`else
        // Fill and wrap: fifth byte stalls until a pop frees a slot.
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        check("fill_count", COUNT, 4);
        RCV_DATA = 8'h05;
        RCV_REQ  = 1'b1;
        tick();
        tick();
        tick();
        check("stall_ack",   RCV_ACK, 1'b0);
        check("stall_count", COUNT,   4);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("stall_pop_count", COUNT,   3);
        check("stall_pop_ack",   RCV_ACK, 1'b0);
        tick();
        check("stall_write_ack",   RCV_ACK, 1'b1);
        check("stall_write_count", COUNT,   4);
        check("stall_ovf",         OVF_CNT, 0);
        RCV_REQ = 1'b0;
        tick();
        drain_expect(8'h02, 4);
`endif

        // Simultaneous push and pop at COUNT=2.
        send_byte(8'h10);
        send_byte(8'h11);
        check("simul_pre", COUNT, 2);
        RCV_DATA  = 8'h12;
        RCV_REQ   = 1'b1;
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("simul_count", COUNT,    2);
        check("simul_ack",   RCV_ACK,  1'b1);
        check("simul_head",  OUT_DATA, 8'h11);
        RCV_REQ = 1'b0;
        tick();
        drain_expect(8'h11, 2);

        // Timeout: REQ held high, ACK must stay high exactly TIMEOUT cycles.
        RCV_DATA = 8'h77;
        RCV_REQ  = 1'b1;
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (RCV_ACK === 1'b1) hi++;
        end
        check("tmo_ack_cycles", hi,      TIMEOUT);
        check("tmo_hserr",      HS_ERR,  1'b1);
        check("tmo_ack_low",    RCV_ACK, 1'b0);
        check("tmo_count",      COUNT,   1);
        RCV_REQ = 1'b0;
        tick();
        tick();
        send_byte(8'h78);
        check("tmo_recover_count", COUNT,  2);
        check("tmo_sticky",        HS_ERR, 1'b1);
        drain_expect(8'h77, 2);

        // Reset mid-handshake: REQ held across clr must not be re-captured.
        RCV_DATA = 8'h31;
        RCV_REQ  = 1'b1;
        tick();
        check("mid_ack", RCV_ACK, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("mid_rst_ack",   RCV_ACK, 1'b0);
        check("mid_rst_count", COUNT,   0);
        check("mid_rst_hserr", HS_ERR,  1'b0);
        tick();
        tick();
        tick();
        check("mid_no_recap_ack",   RCV_ACK, 1'b0);
        check("mid_no_recap_count", COUNT,   0);
        RCV_REQ = 1'b0;
        tick();
        send_byte(8'h32);
        check("mid_next_count", COUNT,    1);
        check("mid_next_data",  OUT_DATA, 8'h32);
        drain_expect(8'h32, 1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
